// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared constants and helpers for the UART receive path.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_STOP    = 3'd4;
  localparam logic [2:0] ST_DELIVER = 3'd5;
  localparam logic [2:0] ST_BREAK   = 3'd6;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int uart_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : rxd synchroniser, oversample tick counter and bit-centre sampler.
//            Define UART_RX_MAJORITY_EN for a 2-of-3 vote around the centre.
// Revision : 1.0
// ============================================================================
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic divclk,
  input  logic rst,
  input  logic rxd,
  input  logic cnt_clr,
  input  logic half_bit,
  output logic rxs,
  output logic sample_strobe,
  output logic sample_bit
);

  localparam int                c_tw   = uart_clog2(OVERSAMPLE);
  localparam logic [c_tw-1:0]   c_full = c_tw'(OVERSAMPLE - 1);
  localparam logic [c_tw-1:0]   c_half = c_tw'(OVERSAMPLE / 2 - 1);

  logic            r_sync1;
  logic            r_rxs;
  logic [c_tw-1:0] r_tcnt;
  logic            w_centre;

  assign w_centre = !cnt_clr && (r_tcnt == (half_bit ? c_half : c_full));
  assign rxs      = r_rxs;

  always_ff @(posedge divclk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_tcnt  <= '0;
    end else begin
      r_sync1 <= rxd;
      r_rxs   <= r_sync1;
      // Wrapping at the centre keeps every later centre exactly one bit apart
      if (cnt_clr || w_centre) r_tcnt <= '0;
      else                     r_tcnt <= r_tcnt + c_tw'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;
  logic       r_strobe_d;

  always_ff @(posedge divclk or negedge rst) begin
    if (!rst) begin
      r_hist     <= 2'b11;
      r_strobe_d <= 1'b0;
    end else begin
      r_hist     <= {r_hist[0], r_rxs};
      r_strobe_d <= w_centre;
    end
  end

  // One cycle after the centre: r_hist holds centre-1/centre, r_rxs is centre+1
  assign sample_strobe = r_strobe_d && !cnt_clr;
  assign sample_bit    = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rxs) | (r_hist[0] & r_rxs);
`else
  assign sample_strobe = w_centre;
  assign sample_bit    = r_rxs;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Brief    : Parametrised UART receiver with valid/ready holding register.
//            Majority sampling selected by UART_RX_MAJORITY_EN.
// Revision : 1.0
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0,
  parameter int LSB_FIRST   = 1
) (
  input  logic                 divclk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           state
);

  localparam int              c_bw       = uart_clog2(DATA_BITS + 1);
  localparam logic [c_bw-1:0] c_last_bit = c_bw'(DATA_BITS - 1);

  logic [2:0]           r_state;
  logic [c_bw-1:0]      r_bcnt;
  logic                 r_scnt;
  logic [DATA_BITS-1:0] r_sr;
  logic                 r_perr;
  logic                 r_ferr;

  logic w_rxs, w_strobe, w_bit;
  logic w_par_err, w_ferr_now, w_stop_last, w_to_break, w_load_evt, w_ferr_load;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .divclk        (divclk),
    .rst           (rst),
    .rxd           (rxd),
    .cnt_clr       (r_state == ST_IDLE),
    .half_bit      (r_state == ST_START),
    .rxs           (w_rxs),
    .sample_strobe (w_strobe),
    .sample_bit    (w_bit)
  );

  assign w_par_err   = ((^r_sr) ^ w_bit) != (PARITY_MODE == PARITY_ODD);
  assign w_ferr_now  = r_ferr | ~w_bit;
  assign w_stop_last = (r_state == ST_STOP) && w_strobe && (r_scnt == 1'(STOP_BITS - 1));
  assign w_to_break  = w_stop_last && w_ferr_now && !w_rxs;
  // A framed-out word is handed over as the FSM enters BREAK, so its flag is visible
  assign w_load_evt  = (r_state == ST_DELIVER) || w_to_break;
  assign w_ferr_load = (r_state == ST_DELIVER) ? r_ferr : 1'b1;

  assign busy  = (r_state != ST_IDLE);
  assign state = r_state;

  always_ff @(posedge divclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_bcnt  <= '0;
      r_scnt  <= 1'b0;
      r_sr    <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_perr <= 1'b0;
          r_ferr <= 1'b0;
          if (!w_rxs) r_state <= ST_START;
        end
        ST_START: if (w_strobe) begin
          r_bcnt  <= '0;
          r_state <= w_bit ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (w_strobe) begin
          if (LSB_FIRST != 0) r_sr <= {w_bit, r_sr[DATA_BITS-1:1]};
          else                r_sr <= {r_sr[DATA_BITS-2:0], w_bit};
          r_bcnt <= r_bcnt + c_bw'(1);
          r_scnt <= 1'b0;
          if (r_bcnt == c_last_bit)
            r_state <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: if (w_strobe) begin
          r_perr  <= w_par_err;
          r_state <= ST_STOP;
        end
        ST_STOP: if (w_strobe) begin
          r_ferr <= w_ferr_now;
          r_scnt <= r_scnt + 1'b1;
          if (w_stop_last) r_state <= w_to_break ? ST_BREAK : ST_DELIVER;
        end
        ST_DELIVER: r_state <= ST_IDLE;
        ST_BREAK:   if (w_rxs) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge divclk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_load_evt) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= r_sr;
          parity_err <= r_perr;
          frame_err  <= w_ferr_load;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_param
// Brief    : Directed self-checking bench for uart_rx_param (three configurations).
// Revision : 1.0
// ============================================================================
module tb_uart_rx_param;
  import uart_pkg::*;

`ifdef UART_RX_MAJORITY_EN
  localparam int GLITCH_BIT = 4;
`else
  localparam int GLITCH_BIT = -1;
`endif

  logic       divclk = 1'b0;
  logic       rst    = 1'b0;
  logic [2:0] rxd    = 3'b111;
  logic [2:0] rdy    = 3'b111;

  logic [7:0] d0, d1;
  logic [8:0] d2;
  logic       v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, b0, b1, b2;
  logic [2:0] s0, s1, s2;

  int checks = 0;
  int errors = 0;
  int vcnt[3] = '{0, 0, 0};
  int ocnt[3] = '{0, 0, 0};
  logic [15:0] cap_d[3];
  logic        cap_pe[3];
  logic        cap_fe[3];
  int vb, ob;

  always #5 divclk = ~divclk;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_MODE(0), .LSB_FIRST(1)) dut0 (
    .divclk(divclk), .rst(rst), .rxd(rxd[0]), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy[0]),
    .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(b0), .state(s0));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_MODE(1), .LSB_FIRST(1)) dut1 (
    .divclk(divclk), .rst(rst), .rxd(rxd[1]), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy[1]),
    .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1), .state(s1));

  uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(16), .STOP_BITS(2), .PARITY_MODE(0), .LSB_FIRST(0)) dut2 (
    .divclk(divclk), .rst(rst), .rxd(rxd[2]), .rx_data(d2), .rx_valid(v2), .rx_ready(rdy[2]),
    .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(b2), .state(s2));

  always @(negedge divclk) begin
    if (v0) begin vcnt[0]++; cap_d[0] = 16'(d0); cap_pe[0] = pe0; cap_fe[0] = fe0; end
    if (v1) begin vcnt[1]++; cap_d[1] = 16'(d1); cap_pe[1] = pe1; cap_fe[1] = fe1; end
    if (v2) begin vcnt[2]++; cap_d[2] = 16'(d2); cap_pe[2] = pe2; cap_fe[2] = fe2; end
    if (ov0) ocnt[0]++;
    if (ov1) ocnt[1]++;
    if (ov2) ocnt[2]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // par < 0 means no parity bit; gl is the frame bit index (0 = start) to glitch at its centre
  task automatic send(input int sel, input logic [15:0] d, input int nb, input bit lsb,
                      input int par, input bit st1, input bit st2, input int ns, input int gl);
    bit q[$];
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) q.push_back(lsb ? d[i] : d[nb-1-i]);
    if (par >= 0) q.push_back(par[0]);
    q.push_back(st1);
    if (ns == 2) q.push_back(st2);
    @(negedge divclk);
    for (int k = 0; k < q.size(); k++) begin
      rxd[sel] = q[k];
      if (k == gl) begin
        repeat (8) @(negedge divclk);
        rxd[sel] = ~q[k];
        @(negedge divclk);
        rxd[sel] = q[k];
        repeat (7) @(negedge divclk);
      end else begin
        repeat (16) @(negedge divclk);
      end
    end
  endtask

  task automatic idle(input int sel, input int n);
    rxd[sel] = 1'b1;
    repeat (n) @(negedge divclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge divclk);
    chk("rst_valid", v0, 0);
    chk("rst_data", d0, 0);
    chk("rst_perr", pe0, 0);
    chk("rst_ferr", fe0, 0);
    chk("rst_ovr", ov0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_state", s0, ST_IDLE);
    rst = 1'b1;
    repeat (4) @(negedge divclk);

    // Basic 8N1 word
    vb = vcnt[0];
    send(0, 16'h00A5, 8, 1, -1, 1, 1, 1, -1);
    idle(0, 20);
    chk("a5_vcnt", vcnt[0] - vb, 1);
    chk("a5_data", cap_d[0], 16'h00A5);
    chk("a5_perr", cap_pe[0], 0);
    chk("a5_ferr", cap_fe[0], 0);
    chk("a5_state", s0, ST_IDLE);

    // Even parity, correct then wrong parity bit
    vb = vcnt[1];
    send(1, 16'h0007, 8, 1, 1, 1, 1, 1, -1);
    idle(1, 20);
    chk("par_ok_vcnt", vcnt[1] - vb, 1);
    chk("par_ok_data", cap_d[1], 16'h0007);
    chk("par_ok_perr", cap_pe[1], 0);
    vb = vcnt[1];
    send(1, 16'h0007, 8, 1, 0, 1, 1, 1, -1);
    idle(1, 20);
    chk("par_bad_vcnt", vcnt[1] - vb, 1);
    chk("par_bad_data", cap_d[1], 16'h0007);
    chk("par_bad_perr", cap_pe[1], 1);

    // Stop bit low then line held low: break
    vb = vcnt[0];
    send(0, 16'h0055, 8, 1, -1, 0, 1, 1, -1);
    repeat (40) @(negedge divclk);
    chk("brk_state", s0, ST_BREAK);
    chk("brk_busy", b0, 1);
    chk("brk_vcnt", vcnt[0] - vb, 1);
    chk("brk_ferr", cap_fe[0], 1);
    chk("brk_data", cap_d[0], 16'h0055);
    idle(0, 40);
    chk("brk_no_second", vcnt[0] - vb, 1);
    chk("brk_exit_state", s0, ST_IDLE);

    // Overrun with consumer stalled
    rdy[0] = 1'b0;
    ob = ocnt[0];
    send(0, 16'h0011, 8, 1, -1, 1, 1, 1, -1);
    idle(0, 20);
    send(0, 16'h0022, 8, 1, -1, 1, 1, 1, -1);
    idle(0, 20);
    chk("ovr_data", d0, 8'h11);
    chk("ovr_valid", v0, 1);
    chk("ovr_pulses", ocnt[0] - ob, 1);
    rdy[0] = 1'b1;
    @(negedge divclk);
    chk("ovr_valid_drop", v0, 0);

    // Short low glitch on idle line
    vb = vcnt[0];
    rxd[0] = 1'b0;
    repeat (3) @(negedge divclk);
    rxd[0] = 1'b1;
    repeat (3) @(negedge divclk);
    chk("gl_in_start", s0, ST_START);
    repeat (20) @(negedge divclk);
    chk("gl_state", s0, ST_IDLE);
    chk("gl_vcnt", vcnt[0] - vb, 0);

    // Reset in the middle of the data bits
    rxd[0] = 1'b0;
    repeat (56) @(negedge divclk);
    chk("mid_state", s0, ST_DATA);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_state", s0, ST_IDLE);
    chk("mid_rst_busy", b0, 0);
    chk("mid_rst_valid", v0, 0);
    chk("mid_rst_data", d0, 0);
    chk("mid_rst_ovr", ov0, 0);
    rxd[0] = 1'b1;
    @(negedge divclk);
    rst = 1'b1;
    repeat (5) @(negedge divclk);
    vb = vcnt[0];
    send(0, 16'h003C, 8, 1, -1, 1, 1, 1, -1);
    idle(0, 20);
    chk("post_rst_vcnt", vcnt[0] - vb, 1);
    chk("post_rst_data", cap_d[0], 16'h003C);

    // 9 bits, MSB first, two stop bits
    vb = vcnt[2];
    send(2, 16'h01B3, 9, 0, -1, 1, 1, 2, GLITCH_BIT);
    idle(2, 20);
    chk("w9_vcnt", vcnt[2] - vb, 1);
    chk("w9_data", cap_d[2], 16'h01B3);
    chk("w9_ferr", cap_fe[2], 0);
    vb = vcnt[2];
    send(2, 16'h00C3, 9, 0, -1, 1, 0, 2, -1);
    idle(2, 30);
    chk("w9_stop2_vcnt", vcnt[2] - vb, 1);
    chk("w9_stop2_ferr", cap_fe[2], 1);
    chk("w9_stop2_data", cap_d[2], 16'h00C3);
    chk("w9_stop2_state", s2, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
